alu_unit: RTL and testbench

Execution-side responder for the reservation-station issue interface. Accepts one ready instruction per cycle (rob id, type, op, two operand values), computes the integer or branch-compare result, buffers it in a small in-order result queue, and broadcasts it on the ALU common data bus to the reservation station, ROB and load/store unit. It sits between the reservation station and the CDB. It backpressures issue through `_alu_full`.

---
 rtl/alu_unit.sv | 131 +++++++++++++
 tb/tb_alu_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_unit.sv
// ALU execution unit: computes integer/branch-compare results on issue and
// broadcasts them in order on the CDB. Optional ALU_STATS_EN adds counters.
module alu_unit #(
  parameter int DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        _clear,
  input  logic        _alu_ready,
  input  logic [4:0]  _alu_rob_id,
  input  logic [6:0]  _alu_type,
  input  logic [3:0]  _alu_op,
  input  logic [31:0] _alu_v1,
  input  logic [31:0] _alu_v2,
  output logic        _alu_full,
  input  logic        _cdb_stall,
  output logic        _cdb_ready,
  output logic [4:0]  _cdb_rob_id,
  output logic [31:0] _cdb_value
`ifdef ALU_STATS_EN
  ,
  output logic [31:0] _alu_stat_ops,
  output logic [31:0] _alu_stat_full
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  logic [4:0]  r_rob [DEPTH];
  logic [31:0] r_val [DEPTH];
  logic [AW-1:0] r_head, r_tail;
  logic [AW:0]   r_count;

  logic [31:0] w_result;
  logic [4:0]  w_shamt;
  logic        w_alt;
  logic        w_push, w_pop;

  assign w_shamt = _alu_v2[4:0];
  // funct7[5] only matters for R-type ADD/SUB and for the right-shift pair
  assign w_alt   = _alu_op[3] && ((_alu_type == OP_R) || (_alu_op[2:0] == 3'b101));

  always_comb begin
    w_result = _alu_v1 + _alu_v2;
    if (_alu_type == OP_R || _alu_type == OP_I) begin
      case (_alu_op[2:0])
        3'b000: w_result = w_alt ? (_alu_v1 - _alu_v2) : (_alu_v1 + _alu_v2);
        3'b001: w_result = _alu_v1 << w_shamt;
        3'b010: w_result = {31'd0, $signed(_alu_v1) < $signed(_alu_v2)};
        3'b011: w_result = {31'd0, _alu_v1 < _alu_v2};
        3'b100: w_result = _alu_v1 ^ _alu_v2;
        3'b101: w_result = w_alt ? 32'($signed(_alu_v1) >>> w_shamt) : (_alu_v1 >> w_shamt);
        3'b110: w_result = _alu_v1 | _alu_v2;
        default: w_result = _alu_v1 & _alu_v2;
      endcase
    end else if (_alu_type == OP_BR) begin
      case (_alu_op[2:0])
        3'b000: w_result = {31'd0, _alu_v1 == _alu_v2};
        3'b001: w_result = {31'd0, _alu_v1 != _alu_v2};
        3'b100: w_result = {31'd0, $signed(_alu_v1) <  $signed(_alu_v2)};
        3'b101: w_result = {31'd0, $signed(_alu_v1) >= $signed(_alu_v2)};
        3'b110: w_result = {31'd0, _alu_v1 <  _alu_v2};
        3'b111: w_result = {31'd0, _alu_v1 >= _alu_v2};
        default: w_result = 32'd0;
      endcase
    end else if (_alu_type == OP_LUI) begin
      w_result = _alu_v2;
    end
  end

  assign _alu_full   = (r_count == LP_FULL);
  assign _cdb_ready  = (r_count != '0) && !_cdb_stall;
  assign _cdb_rob_id = _cdb_ready ? r_rob[r_head] : 5'd0;
  assign _cdb_value  = _cdb_ready ? r_val[r_head] : 32'd0;

  assign w_push = _alu_ready && !_alu_full && rdy_in;
  assign w_pop  = _cdb_ready && rdy_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rob[i] <= '0;
        r_val[i] <= '0;
      end
    end else if (_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (rdy_in) begin
      if (w_push) begin
        r_rob[r_tail] <= _alu_rob_id;
        r_val[r_tail] <= w_result;
        r_tail        <= r_tail + 1'b1;
      end
      if (w_pop) r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef ALU_STATS_EN
  logic [31:0] r_stat_ops, r_stat_full;
  assign _alu_stat_ops  = r_stat_ops;
  assign _alu_stat_full = r_stat_full;

  // counters survive a flush; an issue discarded by the flush is not counted
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_stat_ops  <= '0;
      r_stat_full <= '0;
    end else if (rdy_in) begin
      if (w_push && !_clear) r_stat_ops  <= r_stat_ops + 32'd1;
      if (_alu_full)         r_stat_full <= r_stat_full + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: vector table plus queue/flush/freeze sequences.
module tb_alu_unit;

  logic        clk_in = 0, rst_in = 1, rdy_in = 1, _clear = 0, _alu_ready = 0;
  logic [4:0]  _alu_rob_id = 0;
  logic [6:0]  _alu_type = 0;
  logic [3:0]  _alu_op = 0;
  logic [31:0] _alu_v1 = 0, _alu_v2 = 0;
  logic        _alu_full, _cdb_stall = 0, _cdb_ready;
  logic [4:0]  _cdb_rob_id;
  logic [31:0] _cdb_value;

  alu_unit #(.DEPTH(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), ._clear(_clear),
    ._alu_ready(_alu_ready), ._alu_rob_id(_alu_rob_id), ._alu_type(_alu_type),
    ._alu_op(_alu_op), ._alu_v1(_alu_v1), ._alu_v2(_alu_v2), ._alu_full(_alu_full),
    ._cdb_stall(_cdb_stall), ._cdb_ready(_cdb_ready), ._cdb_rob_id(_cdb_rob_id),
    ._cdb_value(_cdb_value)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [6:0]  typ;
    logic [3:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [4:0]  rob;
    logic [31:0] val;
  } sb_t;

  sb_t sb[$];
  int  n_vec = 0, n_err = 0;

  localparam logic [6:0] TR = 7'b0110011, TI = 7'b0010011, TB = 7'b1100011;
  localparam logic [6:0] TL = 7'b0110111, TA = 7'b0010111;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // broadcast monitor: every accepted broadcast must match the scoreboard head
  always @(negedge clk_in) begin
    if (!rst_in && _cdb_ready && rdy_in) begin
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL spurious_cdb: got rob %0d value 0x%08h want no broadcast", _cdb_rob_id, _cdb_value);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("cdb_rob", 32'(_cdb_rob_id), 32'(e.rob));
        chk("cdb_val", _cdb_value, e.val);
      end
    end
  end

  task automatic step();
    @(posedge clk_in); #1;
  endtask

  // drive one issue for one edge; push the expectation when the model says it is accepted
  task automatic issue(input logic [4:0] rob, input logic [6:0] t, input logic [3:0] op,
                       input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] exp,
                       input bit expect_push);
    _alu_ready = 1; _alu_rob_id = rob; _alu_type = t; _alu_op = op; _alu_v1 = v1; _alu_v2 = v2;
    if (expect_push) sb.push_back('{rob, exp});
    step();
    _alu_ready = 0;
  endtask

  vec_t vt[$];

  initial begin
    vt.push_back('{TR, 4'b0000, 32'd5,        32'd7,        32'd12});
    vt.push_back('{TR, 4'b1000, 32'd0,        32'd1,        32'hFFFFFFFF});
    vt.push_back('{TR, 4'b0001, 32'd1,        32'h24,       32'd16});
    vt.push_back('{TR, 4'b0010, 32'hFFFFFFFF, 32'd0,        32'd1});
    vt.push_back('{TR, 4'b0011, 32'd1,        32'hFFFFFFFF, 32'd1});
    vt.push_back('{TR, 4'b0100, 32'hF0,       32'hFF,       32'h0F});
    vt.push_back('{TR, 4'b0101, 32'h80000000, 32'd31,       32'd1});
    vt.push_back('{TR, 4'b1101, 32'h80000000, 32'd31,       32'hFFFFFFFF});
    vt.push_back('{TR, 4'b0110, 32'hF0,       32'h0F,       32'hFF});
    vt.push_back('{TR, 4'b0111, 32'hF0,       32'h3C,       32'h30});
    vt.push_back('{TI, 4'b1000, 32'd1,        32'd1,        32'd2});
    vt.push_back('{TI, 4'b1101, 32'h80000000, 32'd4,        32'hF8000000});
    vt.push_back('{TI, 4'b0101, 32'h80000000, 32'd4,        32'h08000000});
    vt.push_back('{TI, 4'b1010, 32'hFFFFFFFF, 32'd0,        32'd1});
    vt.push_back('{TB, 4'b0100, 32'hFFFFFFFF, 32'd0,        32'd1});
    vt.push_back('{TB, 4'b0110, 32'hFFFFFFFF, 32'd0,        32'd0});
    vt.push_back('{TB, 4'b0001, 32'd4,        32'd4,        32'd0});
    vt.push_back('{TB, 4'b0000, 32'd4,        32'd4,        32'd1});
    vt.push_back('{TB, 4'b0101, 32'd0,        32'hFFFFFFFF, 32'd1});
    vt.push_back('{TB, 4'b0111, 32'd0,        32'hFFFFFFFF, 32'd0});
    vt.push_back('{TB, 4'b0010, 32'd4,        32'd4,        32'd0});
    vt.push_back('{TL, 4'b0000, 32'd5,        32'h12345000, 32'h12345000});
    vt.push_back('{TA, 4'b0000, 32'hFFFFFFFF, 32'd2,        32'd1});

    repeat (3) step();
    rst_in = 0;
    @(negedge clk_in);
    chk("rst_full",  32'(_alu_full),    0);
    chk("rst_ready", 32'(_cdb_ready),   0);
    chk("rst_rob",   32'(_cdb_rob_id),  0);
    chk("rst_val",   _cdb_value,        0);
    step();

    // single op: one-cycle latency then idle
    issue(5'd3, TR, 4'b0000, 32'd5, 32'd7, 32'd12, 1);
    @(negedge clk_in);
    chk("single_ready", 32'(_cdb_ready), 1);
    chk("single_rob",   32'(_cdb_rob_id), 3);
    chk("single_val",   _cdb_value, 12);
    step();
    @(negedge clk_in);
    chk("single_idle", 32'(_cdb_ready), 0);
    step();

    // vector table, issued back to back
    foreach (vt[i]) issue(5'(i), vt[i].typ, vt[i].op, vt[i].v1, vt[i].v2, vt[i].exp, 1);
    repeat (3) step();
    chk("vec_drain", 32'(sb.size()), 0);

    // backpressure and ordering
    _cdb_stall = 1;
    for (int k = 1; k <= 4; k++) issue(5'(k), TR, 4'b0000, 32'(k), 32'd100, 32'(k + 100), 1);
    @(negedge clk_in);
    chk("bp_full", 32'(_alu_full), 1);
    step();
    issue(5'd5, TR, 4'b0000, 32'd5, 32'd100, 32'd105, 0);
    @(negedge clk_in);
    chk("bp_drop_full", 32'(_alu_full), 1);
    chk("bp_stalled",   32'(_cdb_ready), 0);
    step();
    _cdb_stall = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_in);
      chk("bp_order_rdy", 32'(_cdb_ready), 1);
      chk("bp_order_rob", 32'(_cdb_rob_id), 32'(k));
      step();
    end
    @(negedge clk_in);
    chk("bp_empty", 32'(_cdb_ready), 0);
    step();

    // flush with a concurrent issue
    _cdb_stall = 1;
    for (int k = 0; k < 3; k++) issue(5'(10 + k), TR, 4'b0000, 32'(k), 32'd1, 32'(k + 1), 1);
    _clear = 1;
    issue(5'd9, TR, 4'b0000, 32'd9, 32'd9, 32'd18, 0);
    _clear = 0; _cdb_stall = 0;
    sb.delete();
    @(negedge clk_in);
    chk("flush_ready", 32'(_cdb_ready), 0);
    chk("flush_full",  32'(_alu_full), 0);
    repeat (4) step();

    // freeze with two entries queued
    _cdb_stall = 1;
    issue(5'd20, TR, 4'b0100, 32'hAA, 32'h55, 32'hFF, 1);
    issue(5'd21, TR, 4'b0000, 32'd40, 32'd2, 32'd42, 1);
    rdy_in = 0; _cdb_stall = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_in);
      chk("frz_ready", 32'(_cdb_ready), 1);
      chk("frz_rob",   32'(_cdb_rob_id), 20);
      chk("frz_val",   _cdb_value, 32'hFF);
      step();
    end
    rdy_in = 1;
    @(negedge clk_in);
    chk("thaw_rob0", 32'(_cdb_rob_id), 20);
    step();
    @(negedge clk_in);
    chk("thaw_rob1", 32'(_cdb_rob_id), 21);
    step();
    @(negedge clk_in);
    chk("thaw_empty", 32'(_cdb_ready), 0);
    chk("sb_empty",   32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
